booth_shift_seq: RTL
====================

BOOTH_SHIFT_SEQ -- requirements
Module: booth_shift_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand width; the register is 2*WIDTH+1 bits wide, laid out {A[WIDTH-1:0], Q[WIDTH-1:0], q_m1}.
REQ-002 Parameter SHIFT, default 2, bits shifted per step; legal values are 1 (radix-2) and 2 (radix-4); WIDTH SHALL be a multiple of SHIFT.
REQ-003 Derived constant STEPS = WIDTH/SHIFT, the number of steps per operation.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 n_rst  input  1  asynchronous, active-low reset.
REQ-006 i_start  input  1  loads i_data and begins an operation; sampled only in IDLE.
REQ-007 i_data  input  2*WIDTH+1  initial register value {A, Q, q_m1}.
REQ-008 i_step_en  input  1  performs one step in RUN when high.
REQ-009 i_upd_valid  input  1  when high during a step, A is replaced by i_upd before the shift.
REQ-010 i_upd  input  WIDTH  new A value (partial sum from the external adder).
REQ-011 i_abort  input  1  synchronous cancel of the operation in progress.
REQ-012 o_data  output  2*WIDTH+1  current register contents.
REQ-013 o_booth_bits  output  SHIFT+1  o_data[SHIFT:0], the recoding window for the next step.
REQ-014 o_step_cnt  output  $clog2(STEPS+1)  number of steps completed in the current operation.
REQ-015 o_busy  output  1  high while in RUN.
REQ-016 o_done  output  1  high for exactly one cycle when an operation completes.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 IDLE with i_start=1: at that edge the register loads i_data, o_step_cnt clears to 0, and the FSM moves to RUN.
REQ-019 IDLE with i_start=0: the register holds its value.
REQ-020 RUN with i_step_en=1: next = ASR_SHIFT({(i_upd_valid ? i_upd : A), Q, q_m1}), arithmetic shift right by SHIFT with bit 2*WIDTH replicated into the vacated MSBs; o_step_cnt increments by 1.
REQ-021 RUN with i_step_en=0: the register and o_step_cnt hold.
REQ-022 A step taken while o_step_cnt == STEPS-1 SHALL move the FSM to DONE, and o_step_cnt SHALL reach STEPS.
REQ-023 DONE: o_done=1 and the register holds; the FSM returns to IDLE on the next edge unconditionally.
REQ-024 o_data is valid as the final result from the DONE cycle onward and SHALL be held in IDLE until the next load.
REQ-025 i_start in RUN or DONE SHALL be ignored (no reload, no effect on o_step_cnt).
REQ-026 i_abort in RUN or DONE: the FSM goes to IDLE, the register holds, o_step_cnt clears, and o_done is not asserted.
REQ-027 i_abort has priority over i_step_en.
REQ-028 i_abort in IDLE is ignored.
REQ-029 i_abort and i_start together in IDLE: i_start wins.
REQ-030 i_upd_valid and i_upd SHALL be ignored whenever no step is taken.
REQ-031 o_busy=1 exactly in RUN; o_done=1 exactly in DONE; all outputs are registered or decoded from registered state.
REQ-032 Minimum latency from i_start to o_done is STEPS+1 cycles, with i_step_en held high continuously.

Reset
REQ-033 While n_rst=0, without waiting for clk:
- FSM goes to IDLE
- o_data = 0, o_step_cnt = 0, o_busy = 0, o_done = 0
REQ-034 A reset asserted mid-operation SHALL discard the operation; no o_done follows.
REQ-035 After reset deasserts, the first i_start SHALL be honoured on the first rising edge.

Verification (WIDTH=8 unless stated)
REQ-036 SHIFT=2; load 17'h1_0000; four steps, no update -> o_data=17'h1_FF00; o_done pulses once, 5 cycles after start.
REQ-037 SHIFT=2; load 17'h0_0F12; four steps, no update -> o_data=17'h0_000F; o_step_cnt sequence 0,1,2,3,4.
REQ-038 SHIFT=2; load 17'h0_0003; first step with i_upd_valid=1, i_upd=8'h05 -> o_data=17'h0_0280; o_booth_bits=3'b000.
REQ-039 SHIFT=1; load 17'h1_FFFF; step with i_step_en toggling 1,0,1,... -> register changes only on enabled cycles; o_done after 8 enabled steps; value stays 17'h1_FFFF throughout.
REQ-040 Abort and reset, SHIFT=2:
- i_abort after 2 steps -> IDLE, o_step_cnt=0, no o_done, o_data holds.
- i_start during RUN -> ignored.
REQ-041 n_rst pulsed low between clock edges mid-RUN -> all outputs 0 immediately; a new i_start then completes normally.

Source files
------------

// File: rtl/booth_shift_seq.sv
// Booth multiplier shift sequencer.
// Holds the {A, Q, q_m1} working register for a radix-2 or radix-4 Booth
// multiplier. An external adder supplies the partial sum. Each enabled step
// optionally replaces A with that partial sum. It then arithmetic-shifts
// the whole register right by SHIFT bits.
module booth_shift_seq #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 2,
  localparam int STEPS = WIDTH / SHIFT,
  localparam int CNT_W = $clog2(STEPS + 1)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               i_start,
  input  logic [2*WIDTH:0]   i_data,
  input  logic               i_step_en,
  input  logic               i_upd_valid,
  input  logic [WIDTH-1:0]   i_upd,
  input  logic               i_abort,
  output logic [2*WIDTH:0]   o_data,
  output logic [SHIFT:0]     o_booth_bits,
  output logic [CNT_W-1:0]   o_step_cnt,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH:0]   data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   step_word;
  logic [2*WIDTH:0]   shifted;

  // State, working register and step counter; reset clears everything at once
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, next register value and next count; abort outranks stepping
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    step_word = {(i_upd_valid ? i_upd : data_q[2*WIDTH:WIDTH+1]), data_q[WIDTH:0]};
    shifted   = $signed(step_word) >>> SHIFT;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          data_d  = i_data;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (i_abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (i_step_en) begin
          data_d = shifted;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(STEPS - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (i_abort) begin
          cnt_d = '0;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_data       = data_q;
  assign o_booth_bits = data_q[SHIFT:0];
  assign o_step_cnt   = cnt_q;
  assign o_busy       = (state_q == RUN);
  assign o_done       = (state_q == DONE);

endmodule
